sample_dac_writer: RTL and testbench

Consumes the 12-bit sample stream and one-cycle `ready` strobe produced by the sample generator. Serialises each sample into a 32-bit SPI write-and-update frame for the board's LTC2624 quad DAC. Holds one pending sample so a new strobe can arrive while a frame is in flight. Sits between the sample generator and the DAC pins at the top level.

---
 rtl/sample_dac_writer.sv | 159 +++++++++++++++
 tb/tb_sample_dac_writer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_dac_writer.sv
// rtl/sample_dac_writer.sv - serialises 12-bit samples into LTC2624 SPI write-and-update frames
module sample_dac_writer #(
   parameter int         SCK_DIV      = 2,
   parameter int         CS_GAP       = 4,
   parameter logic [3:0] DAC_ADDR     = 4'b1111,
   parameter bit         INPUT_SIGNED = 1'b0
) (
   input  logic        inCLK_50MHZ,
   input  logic        inRST_N,
   input  logic [11:0] inSample,
   input  logic        inSampleReady,
   output logic        outSPI_SCK,
   output logic        outSPI_MOSI,
   output logic        outDAC_CS_N,
   output logic        outDAC_CLR_N,
   output logic        outBusy,
   output logic        outOverrun
);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      HOLD,
      GAP
   } state_t;

   // Last count value of each SCK half-period and of the inter-frame gap.
   // The IDLE cycle that launches the next frame is the final gap clock,
   // so GAP itself lasts CS_GAP-1 clocks and is skipped when CS_GAP is 1.
   localparam logic [7:0] DIV_LAST   = 8'(SCK_DIV - 1);
   localparam int         GAP_LAST_I = (CS_GAP >= 2) ? CS_GAP - 2 : 0;
   localparam logic [7:0] GAP_LAST   = 8'(GAP_LAST_I);
   localparam bit         GAP_SKIP   = (CS_GAP <= 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [4:0]  bit_cnt;
   logic [31:0] shreg;
   logic        pending;
   logic [11:0] pend_sample;

   logic [11:0] conv_sample;
   logic [31:0] frame_word;
   logic        take;
   logic        pending_nxt;
   logic        fsm_to_idle;
   logic        busy_nxt;

   // Sample conversion, frame assembly and next-cycle pending/busy terms
   always_comb begin
      conv_sample = INPUT_SIGNED ? {~inSample[11], inSample[10:0]} : inSample;
      frame_word  = {8'h00, 4'b0011, DAC_ADDR, pend_sample, 4'h0};
      take        = (state == IDLE) && pending;
      pending_nxt = inSampleReady | (pending & ~take);
      fsm_to_idle = ((state == GAP) && (cnt == GAP_LAST)) ||
                    ((state == HOLD) && (cnt == DIV_LAST) && GAP_SKIP);
      busy_nxt    = pending_nxt | ((state == IDLE) ? take : ~fsm_to_idle);
   end

   // Single-entry pending slot; newest strobe wins, flag lost samples
   always_ff @(posedge inCLK_50MHZ or negedge inRST_N) begin
      if (!inRST_N) begin
         pending     <= 1'b0;
         pend_sample <= 12'h000;
         outOverrun  <= 1'b0;
      end else begin
         pending    <= pending_nxt;
         outOverrun <= inSampleReady & pending & ~take;
         if (inSampleReady) begin
            pend_sample <= conv_sample;
         end
      end
   end

   // Registered status outputs; CLR_N releases one clock after reset
   always_ff @(posedge inCLK_50MHZ or negedge inRST_N) begin
      if (!inRST_N) begin
         outDAC_CLR_N <= 1'b0;
         outBusy      <= 1'b0;
      end else begin
         outDAC_CLR_N <= 1'b1;
         outBusy      <= busy_nxt;
      end
   end

   // Frame sequencer: SCK phases, MOSI shifting, CS hold and gap
   always_ff @(posedge inCLK_50MHZ or negedge inRST_N) begin
      if (!inRST_N) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         bit_cnt     <= 5'd0;
         shreg       <= 32'h0;
         outSPI_SCK  <= 1'b0;
         outSPI_MOSI <= 1'b0;
         outDAC_CS_N <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (pending) begin
                  shreg       <= frame_word;
                  outSPI_MOSI <= frame_word[31];
                  outDAC_CS_N <= 1'b0;
                  cnt         <= 8'd0;
                  bit_cnt     <= 5'd0;
                  state       <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (cnt == DIV_LAST) begin
                  outSPI_SCK <= 1'b1;
                  cnt        <= 8'd0;
                  state      <= SHIFT_HI;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            SHIFT_HI: begin
               if (cnt == DIV_LAST) begin
                  outSPI_SCK <= 1'b0;
                  cnt        <= 8'd0;
                  if (bit_cnt == 5'd31) begin
                     state <= HOLD;
                  end else begin
                     bit_cnt     <= bit_cnt + 5'd1;
                     shreg       <= shreg << 1;
                     outSPI_MOSI <= shreg[30];
                     state       <= SHIFT_LO;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            HOLD: begin
               if (cnt == DIV_LAST) begin
                  outDAC_CS_N <= 1'b1;
                  outSPI_MOSI <= 1'b0;
                  cnt         <= 8'd0;
                  state       <= GAP_SKIP ? IDLE : GAP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= 8'd0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sample_dac_writer.sv
// tb/tb_sample_dac_writer.sv - scoreboard bench for sample_dac_writer
module tb_sample_dac_writer;

   localparam int         SCK_DIV   = 2;
   localparam int         CS_GAP    = 4;
   localparam logic [3:0] DAC_ADDR  = 4'b1111;
   localparam int         FRAME_LEN = 2 * 32 * SCK_DIV + SCK_DIV;
   localparam int         CYCLE_LEN = FRAME_LEN + CS_GAP;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] smp;
   logic        rdy;
   logic        sck, mosi, cs_n, clr_n, busy, ovr;
   logic [11:0] s_smp;
   logic        s_rdy;
   logic        s_sck, s_mosi, s_cs, s_clr, s_busy, s_ovr;

   always #10 clk = ~clk;

   sample_dac_writer #(.SCK_DIV(SCK_DIV), .CS_GAP(CS_GAP), .DAC_ADDR(DAC_ADDR), .INPUT_SIGNED(1'b0)) u_dut (
      .inCLK_50MHZ(clk), .inRST_N(rst_n), .inSample(smp), .inSampleReady(rdy),
      .outSPI_SCK(sck), .outSPI_MOSI(mosi), .outDAC_CS_N(cs_n), .outDAC_CLR_N(clr_n),
      .outBusy(busy), .outOverrun(ovr)
   );

   sample_dac_writer #(.SCK_DIV(SCK_DIV), .CS_GAP(CS_GAP), .DAC_ADDR(DAC_ADDR), .INPUT_SIGNED(1'b1)) u_sgn (
      .inCLK_50MHZ(clk), .inRST_N(rst_n), .inSample(s_smp), .inSampleReady(s_rdy),
      .outSPI_SCK(s_sck), .outSPI_MOSI(s_mosi), .outDAC_CS_N(s_cs), .outDAC_CLR_N(s_clr),
      .outBusy(s_busy), .outOverrun(s_ovr)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] word;
      int          start;
   } exp_t;
   exp_t exp_q[$];

   function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endfunction

   function automatic logic [31:0] frame_of(input logic [11:0] s);
      return {8'h00, 4'b0011, DAC_ADDR, s, 4'h0};
   endfunction

   // Reference model: one pending slot, transmitter free again CYCLE_LEN after a frame starts
   int          cyc = 0;
   bit          m_pend = 0;
   logic [11:0] m_val = 12'h000;
   int          m_free = 0;
   bit          m_took;
   bit          exp_ovr = 0;
   int          ovr_expected = 0;

   always @(posedge clk) begin
      cyc     = cyc + 1;
      exp_ovr = 0;
      if (!rst_n) begin
         m_pend = 0;
         m_free = 0;
      end else begin
         m_took = 0;
         if (m_pend && cyc >= m_free) begin
            exp_q.push_back('{frame_of(m_val), cyc});
            m_free = cyc + CYCLE_LEN;
            m_pend = 0;
            m_took = 1;
         end
         if (rdy) begin
            if (m_pend) begin
               exp_ovr = 1;
               ovr_expected++;
            end
            m_pend = 1;
            m_val  = smp;
         end
      end
   end

   // Monitor: decode SPI frames and compare against the scoreboard
   bit          prev_cs = 1, prev_sck = 0, prev_mosi = 0, in_frame = 0;
   logic [31:0] cap;
   logic [31:0] last_word = 32'h0;
   int          rises = 0, fstart = 0, frames = 0, ovr_seen = 0;
   exp_t        e;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame  = 0;
         prev_cs   = 1;
         prev_sck  = 0;
         prev_mosi = 0;
      end else begin
         if (exp_ovr || ovr) chk("overrun_pulse", {31'd0, ovr}, {31'd0, exp_ovr});
         if (ovr) ovr_seen++;
         if (in_frame && !cs_n && mosi !== prev_mosi)
            chk("mosi_change_on_sck_fall", {31'd0, prev_sck && !sck}, 32'd1);
         if (!in_frame && cs_n && sck) chk("sck_outside_frame", {31'd0, sck}, 32'd0);
         if (prev_cs && !cs_n) begin
            in_frame = 1;
            fstart   = cyc;
            cap      = 32'h0;
            rises    = 0;
         end else if (in_frame && sck && !prev_sck) begin
            cap = {cap[30:0], mosi};
            rises++;
         end
         if (in_frame && cs_n && !prev_cs) begin
            in_frame  = 0;
            frames++;
            last_word = cap;
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", cap, 32'hxxxx_xxxx);
            end else begin
               e = exp_q.pop_front();
               chk("frame_word", cap, e.word);
               chk("frame_start_cycle", fstart, e.start);
               chk("sck_rises", rises, 32);
               chk("cs_low_clocks", cyc - fstart, FRAME_LEN);
            end
         end
         prev_cs   = cs_n;
         prev_sck  = sck;
         prev_mosi = mosi;
      end
   end

   task automatic strobe(input logic [11:0] v);
      @(negedge clk);
      smp = v;
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
      smp = 12'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while ((exp_q.size() != 0 || m_pend || busy || !cs_n) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("drain_within_budget", {31'd0, k < budget}, 32'd1);
   endtask

   task automatic sgn_frame(input logic [11:0] s, input logic [11:0] want);
      logic [31:0] w = 32'h0;
      int          r = 0;
      int          k = 0;
      bit          ps = 0;
      @(negedge clk);
      s_smp = s;
      s_rdy = 1'b1;
      @(negedge clk);
      s_rdy = 1'b0;
      while (s_cs && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("sgn_cs_fall", {31'd0, s_cs}, 32'd0);
      k = 0;
      while (r < 32 && k < 400) begin
         @(negedge clk);
         k++;
         if (s_sck && !ps) begin
            w = {w[30:0], s_mosi};
            r++;
         end
         ps = s_sck;
      end
      chk("sgn_rises", r, 32);
      chk("sgn_word", w, frame_of(want));
      k = 0;
      while ((s_busy || !s_cs) && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("sgn_idle", {31'd0, s_busy}, 32'd0);
   endtask

   int          f0, o0, oe0, k;
   logic [11:0] r12;

   initial begin
      rst_n = 1'b0;
      smp   = 12'h000;
      rdy   = 1'b0;
      s_smp = 12'h000;
      s_rdy = 1'b0;
      idle(4);
      chk("rst_sck", {31'd0, sck}, 32'd0);
      chk("rst_mosi", {31'd0, mosi}, 32'd0);
      chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
      chk("rst_clr_n", {31'd0, clr_n}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_overrun", {31'd0, ovr}, 32'd0);
      #5 rst_n = 1'b1;
      #1 chk("clr_n_before_edge", {31'd0, clr_n}, 32'd0);
      @(posedge clk);
      #1 chk("clr_n_after_edge", {31'd0, clr_n}, 32'd1);
      idle(20);
      chk("idle_sck", {31'd0, sck}, 32'd0);
      chk("idle_cs_n", {31'd0, cs_n}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // Single frame with the reference sample
      f0 = frames;
      strobe(12'hA5C);
      chk("busy_after_strobe", {31'd0, busy}, 32'd1);
      k = 0;
      while (!(in_frame == 0 && frames == f0 + 1) && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("single_frame_seen", frames - f0, 1);
      chk("single_frame_word", last_word, 32'h003F_A5C0);
      chk("busy_during_gap", {31'd0, busy}, 32'd1);
      idle(CS_GAP + 1);
      chk("busy_after_gap", {31'd0, busy}, 32'd0);

      // Overrun: third strobe overwrites an untaken pending sample
      f0 = frames;
      o0 = ovr_seen;
      strobe(12'h111);
      idle(20);
      strobe(12'h222);
      idle(20);
      strobe(12'h333);
      wait_done(600);
      chk("overrun_frames", frames - f0, 2);
      chk("overrun_count", ovr_seen - o0, 1);
      chk("overrun_last_word", last_word, frame_of(12'h333));

      // 40 kHz sample stream
      f0 = frames;
      o0 = ovr_seen;
      for (int i = 0; i < 10; i++) begin
         strobe(12'($urandom));
         idle(1248);
      end
      wait_done(400);
      chk("stream_frames", frames - f0, 10);
      chk("stream_overruns", ovr_seen - o0, 0);

      // Random strobe spacing, overruns arise naturally
      o0  = ovr_seen;
      oe0 = ovr_expected;
      for (int i = 0; i < 30; i++) begin
         strobe(12'($urandom));
         idle($urandom_range(1, 250));
      end
      wait_done(600);
      chk("random_overrun_total", ovr_seen - o0, ovr_expected - oe0);

      // Reset in the middle of a frame
      strobe(12'($urandom));
      k = 0;
      while (!(in_frame && rises == 16) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("reached_rise_16", rises, 16);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_cs_n", {31'd0, cs_n}, 32'd1);
      chk("midrst_sck", {31'd0, sck}, 32'd0);
      chk("midrst_clr_n", {31'd0, clr_n}, 32'd0);
      exp_q.delete();
      idle(3);
      #5 rst_n = 1'b1;
      idle(3);
      f0 = frames;
      strobe(12'($urandom));
      wait_done(400);
      chk("post_reset_frames", frames - f0, 1);

      // Two's complement input converted to offset binary
      sgn_frame(12'h800, 12'h000);
      sgn_frame(12'h7FF, 12'hFFF);
      for (int i = 0; i < 3; i++) begin
         r12 = 12'($urandom);
         sgn_frame(r12, r12 + 12'h800);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
